// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: divides clk into BCLK, sequences LRCLK and MSB-first serial data,
// and pulls stereo sample pairs from upstream through a one-deep holding register.
module i2s_tx_ctrl #(
  parameter int unsigned CLK_DIV = 32,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic              frame_start
);

  localparam int unsigned FrameW = 2 * DATA_W;
  localparam int unsigned CntW   = $clog2(FrameW);

  localparam logic [15:0]     DivLast = 16'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] LrLo    = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] LrHi    = CntW'(FrameW - 2);

  logic [15:0]       half_cnt_q;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FrameW-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic              hold_full_q;
  logic              fall, wrap, lr_d;

  assign s_ready = ~hold_full_q;

  // A fall event is the half-period expiry that drives bclk from 1 to 0.
  always_comb begin
    fall      = enable && (half_cnt_q == 16'd0) && bclk;
    wrap      = (bit_cnt_q == CntLast);
    bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
    shift_d   = {shift_q[FrameW-2:0], 1'b0};
    if (wrap) begin
      shift_d = hold_full_q ? {hold_l_q, hold_r_q} : '0;
    end
    lr_d = (bit_cnt_d >= LrLo) && (bit_cnt_d <= LrHi);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt_q  <= DivLast;
      bit_cnt_q   <= CntLast;
      shift_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      // Capture and frame-load emptying are mutually exclusive: one needs empty, the other full.
      if (s_valid && !hold_full_q) begin
        hold_l_q    <= s_left;
        hold_r_q    <= s_right;
        hold_full_q <= 1'b1;
      end else if (fall && wrap) begin
        hold_full_q <= 1'b0;
      end

      if (!enable) begin
        half_cnt_q <= DivLast;
        bit_cnt_q  <= CntLast;
        shift_q    <= '0;
        bclk       <= 1'b0;
        lrclk      <= 1'b0;
        sdata      <= 1'b0;
      end else if (half_cnt_q == 16'd0) begin
        half_cnt_q <= DivLast;
        bclk       <= ~bclk;
        if (bclk) begin
          bit_cnt_q <= bit_cnt_d;
          shift_q   <= shift_d;
          sdata     <= shift_d[FrameW-1];
          lrclk     <= lr_d;
          if (wrap) begin
            frame_start <= 1'b1;
            underrun    <= ~hold_full_q;
          end
        end
      end else begin
        half_cnt_q <= half_cnt_q - 1'b1;
      end
    end
  end

endmodule
